// File: rtl/port_controller.sv
// Port-mapped I/O block for the command-controlled core: four output registers,
// RX/TX FIFOs to a peripheral, a status port and a synchronized pin port.
module port_controller #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  i_port_id,
    input  logic        i_port_write,
    input  logic        i_port_read,
    input  logic [3:0]  i_cpu_wdata,
    output logic [3:0]  o_cpu_rdata,
    output logic [15:0] o_out_regs,
    output logic [3:0]  o_out_strobe,
    input  logic [3:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [3:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    input  logic [3:0]  i_pins_in
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

    logic [15:0]   r_out_regs;
    logic [3:0]    r_out_strobe;
    logic [3:0]    r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wptr;
    logic [AW-1:0] r_rx_rptr;
    logic [CW-1:0] r_rx_count;
    logic [3:0]    r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_tx_wptr;
    logic [AW-1:0] r_tx_rptr;
    logic [CW-1:0] r_tx_count;
    logic [3:0]    r_pin_meta;
    logic [3:0]    r_pin_sync;

    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic       w_rx_push;
    logic       w_rx_pop;
    logic       w_tx_push;
    logic       w_tx_pop;
    logic       w_reg_write;
    logic [3:0] w_cpu_rdata;

    assign w_rx_empty  = (r_rx_count == '0);
    assign w_rx_full   = (r_rx_count == FULL_COUNT);
    assign w_tx_empty  = (r_tx_count == '0);
    assign w_tx_full   = (r_tx_count == FULL_COUNT);

    // Pops are gated by non-empty, so a push into an empty FIFO always wins.
    assign w_rx_push   = i_rx_valid & ~w_rx_full;
    assign w_rx_pop    = i_port_read & (i_port_id == 3'd4) & ~w_rx_empty;
    assign w_tx_push   = i_port_write & (i_port_id == 3'd6) & ~w_tx_full;
    assign w_tx_pop    = i_tx_ready & ~w_tx_empty;
    assign w_reg_write = i_port_write & ~i_port_id[2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_regs   <= '0;
            r_out_strobe <= '0;
            r_rx_wptr    <= '0;
            r_rx_rptr    <= '0;
            r_rx_count   <= '0;
            r_tx_wptr    <= '0;
            r_tx_rptr    <= '0;
            r_tx_count   <= '0;
            r_pin_meta   <= '0;
            r_pin_sync   <= '0;
        end else begin
            r_out_strobe <= '0;
            if (w_reg_write) begin
                r_out_regs[{i_port_id[1:0], 2'b00} +: 4] <= i_cpu_wdata;
                r_out_strobe[i_port_id[1:0]]             <= 1'b1;
            end

            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase

            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + 1'b1;
                2'b01:   r_tx_count <= r_tx_count - 1'b1;
                default: r_tx_count <= r_tx_count;
            endcase

            r_pin_meta <= i_pins_in;
            r_pin_sync <= r_pin_meta;
        end
    end

    // Storage needs no reset: reads are masked whenever the count says empty.
    always_ff @(posedge clock) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= i_rx_data;
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= i_cpu_wdata;
    end

    always_comb begin
        w_cpu_rdata = '0;
        case (i_port_id)
            3'd0, 3'd1, 3'd2, 3'd3: w_cpu_rdata = r_out_regs[{i_port_id[1:0], 2'b00} +: 4];
            3'd4:    w_cpu_rdata = w_rx_empty ? 4'h0 : r_rx_mem[r_rx_rptr];
            3'd5:    w_cpu_rdata = {w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};
            3'd7:    w_cpu_rdata = r_pin_sync;
            default: w_cpu_rdata = '0;
        endcase
    end

    assign o_cpu_rdata  = w_cpu_rdata;
    assign o_out_regs   = r_out_regs;
    assign o_out_strobe = r_out_strobe;
    assign o_rx_ready   = ~w_rx_full;
    assign o_tx_valid   = ~w_tx_empty;
    assign o_tx_data    = w_tx_empty ? 4'h0 : r_tx_mem[r_tx_rptr];

endmodule

// File: doc/port_controller.md
PORT_CONTROLLER -- requirements
Module: port_controller

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, entries per RX and TX FIFO; power of two, >= 2.
REQ-002 clock  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 port_id  input  3  port address from the command-controlled core.
REQ-005 port_write  input  1  write strobe; write committed at the rising edge where it is high.
REQ-006 port_read  input  1  read strobe; pop side effects at the rising edge where it is high.
REQ-007 cpu_wdata  input  4  write data, driven by the core's result bus.
REQ-008 cpu_rdata  output  4  read data, fed to the core's data input.
REQ-009 out_regs  output  16  output registers 0..3, register n on bits [4n+3:4n].
REQ-010 out_strobe  output  4  one-cycle pulse per output register after it is written.
REQ-011 rx_data  input  4  inbound peripheral data.
REQ-012 rx_valid  input  1  inbound data valid.
REQ-013 rx_ready  output  1  RX FIFO can accept.
REQ-014 tx_data  output  4  outbound data, TX FIFO head.
REQ-015 tx_valid  output  1  TX FIFO non-empty.
REQ-016 tx_ready  input  1  peripheral accepts tx_data.
REQ-017 pins_in  input  4  asynchronous external pins.

Function
REQ-018 Port map SHALL be: 0-3 output registers (R/W), 4 RX FIFO pop (R), 5 status (R), 6 TX FIFO push (W), 7 synchronized pins (R).
REQ-019 cpu_rdata SHALL be combinational from port_id and current state, independent of port_read: ports 0-3 register value; 4 RX head (0 when empty); 5 {rx_empty, rx_full, tx_empty, tx_full} MSB first; 6 0; 7 pin sync register.
REQ-020 Write to port n (0-3) SHALL load out_regs[n] from cpu_wdata at the edge and assert out_strobe[n] for exactly the following cycle.
REQ-021 Writes to ports 4, 5, 7 SHALL be ignored.
REQ-022 Write to port 6 while TX not full SHALL push cpu_wdata; while full the write SHALL be dropped, FIFO unchanged.
REQ-023 Read of port 4 while RX not empty SHALL pop the head at the edge; while empty no state change.
REQ-024 RX push SHALL occur at the edge where rx_valid & rx_ready; rx_ready = ~rx_full (not dependent on a simultaneous pop).
REQ-025 TX pop SHALL occur at the edge where tx_valid & tx_ready; tx_valid = ~tx_empty; tx_data = head, stable while tx_valid & ~tx_ready.
REQ-026 Simultaneous push and pop on a non-empty FIFO SHALL keep occupancy unchanged; on an empty FIFO only the push takes effect.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH; full = count == FIFO_DEPTH, empty = count == 0.
REQ-028 FIFO order SHALL be strictly first-in first-out.
REQ-029 pins_in SHALL pass a two-flop synchronizer; port 7 reads the second stage (2-cycle latency).
REQ-030 Data pushed to TX SHALL appear on tx_valid the cycle after the write edge; RX data pushed SHALL be readable on port 4 the cycle after the push edge.
REQ-031 Simultaneous port_read and port_write SHALL each take effect per own port rules.

Reset
REQ-032 Reset SHALL clear out_regs, out_strobe, both FIFOs (count, pointers) and the synchronizer to 0, immediately and asynchronously.
REQ-033 After reset: rx_ready=1, tx_valid=0, status=4'b1010, cpu_rdata on port 4 = 0.
REQ-034 Reset mid-transfer SHALL discard all buffered data; no stale entry is ever emitted after release.

Verification
REQ-035 Write 4'hA to port 2 -> next cycle out_regs[11:8]=A, out_strobe=4'b0100 for one cycle; port 2 reads A.
REQ-036 Push 3,5,7,9 via RX with port reads idle -> rx_ready=0, status=4'b0110; four port-4 reads return 3,5,7,9 then status=4'b1010.
REQ-037 Five writes 1..5 to port 6 with tx_ready=0 -> fifth dropped, tx_full=1; raise tx_ready -> tx_data 1,2,3,4 on consecutive cycles, then tx_valid=0.
REQ-038 RX holding 2 entries, rx_valid and port-4 read same edge -> count stays 2, order preserved.
REQ-039 pins_in set to 4'h6 -> port 7 reads 0 for two edges, 6 after second edge.
REQ-040 Assert reset with both FIFOs partially full -> status=4'b1010, out_regs=0 immediately; later reads of port 4 return 0.
